// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard sequencer for the 5-stage MIPS pipeline.
// Each cycle it decides which pipeline registers advance, which stages take a
// bubble or a flush, and whether the PC updates. It covers icache/dcache hit
// latching, load-use stalls, redirects resolved in MEM and the halt drain.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds the cyc_cnt, stall_cnt and
// flush_cnt performance counter outputs. The default build omits them.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEMWAIT_MAX = 255  // 0 disables the timeout flag
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             imemREN,
  output logic             dmem_req,
  output logic             halt,
  output logic             memwait_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      cyc_cnt,
  output logic [31:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       ihit_seen, dhit_seen;
  logic [7:0] wait_cnt, wait_cnt_nxt;

  logic mem_req;
  logic i_ok, d_ok, advance;
  logic load_use;

  // A hit that arrives while the other cache is still busy is remembered until
  // the pipeline actually advances, so neither response is lost.
  assign mem_req  = mem_dren | mem_dwen;
  assign i_ok     = ihit | ihit_seen;
  assign d_ok     = !mem_req | dhit | dhit_seen;
  assign advance  = i_ok & d_ok;

  // Only a load in ID/EX can hazard; stores never do, and register $0 never
  // carries a dependency.
  assign load_use = ex_dren && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Wait-cycle counter saturates at 8 bits so a stuck dcache cannot wrap it.
  assign wait_cnt_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  // Next-state and per-cycle control decode, highest priority first:
  // halt, memory stall, redirect, load-use, normal advance.
  always_comb begin
    // NOTE: every output and next-state term gets a default before any branch;
    // a path that skips an assignment would otherwise infer a latch.
    state_nxt   = state;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    imemREN     = 1'b1;
    dmem_req    = 1'b0;
    halt        = 1'b0;

    if (!nRST) begin
      // While reset is held, present the quiescent reset values regardless of
      // whatever state the register still holds before the edge.
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_HALTED: begin
          imemREN = 1'b0;
          halt    = 1'b1;
        end

        ST_RUN, ST_MEMWAIT: begin
          // The request stays up for the whole wait; in RUN it drops once the
          // dcache response has been latched.
          dmem_req = (state == ST_MEMWAIT) ? 1'b1 : (mem_req & !dhit_seen);

          if (wb_halt) begin
            state_nxt = ST_HALTED;
          end else if (!advance) begin
            state_nxt = (mem_req && !d_ok) ? ST_MEMWAIT : ST_RUN;
          end else begin
            state_nxt = ST_RUN;
            if (mem_redirect) begin
              // Squash the three younger instructions and load the branch
              // target; a coincident load-use belongs to a squashed slot.
              pc_en       = 1'b1;
              pc_redirect = 1'b1;
              ifid_en     = 1'b1;
              idex_en     = 1'b1;
              exmem_en    = 1'b1;
              memwb_en    = 1'b1;
              ifid_flush  = 1'b1;
              idex_flush  = 1'b1;
              exmem_flush = 1'b1;
            end else if (load_use) begin
              // Hold PC and IF/ID, inject one bubble into ID/EX, let the
              // older instructions (including the load) move on.
              idex_en     = 1'b1;
              idex_flush  = 1'b1;
              exmem_en    = 1'b1;
              memwb_en    = 1'b1;
            end else begin
              pc_en       = 1'b1;
              ifid_en     = 1'b1;
              idex_en     = 1'b1;
              exmem_en    = 1'b1;
              memwb_en    = 1'b1;
            end
          end
        end

        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State register and hit latches; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!nRST) begin
      state     <= ST_RUN;
      ihit_seen <= 1'b0;
      dhit_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_HALTED || advance) begin
        // Halted ignores cache traffic; an advance consumes both hits
        // (including a redirect, which discards the stale fetch).
        ihit_seen <= 1'b0;
        dhit_seen <= 1'b0;
      end else begin
        if (ihit)
          ihit_seen <= 1'b1;
        if (dhit && mem_req)
          dhit_seen <= 1'b1;
      end
    end
  end

  // Dcache wait counter and sticky timeout flag; the wait itself continues
  // after the flag is raised.
  always_ff @(posedge CLK) begin
    // NOTE: every control register here is explicitly reset; there is no
    // storage array whose contents could be left uninitialised.
    if (!nRST) begin
      wait_cnt        <= 8'd0;
      memwait_timeout <= 1'b0;
    end else if (state == ST_MEMWAIT) begin
      wait_cnt <= wait_cnt_nxt;
      if ((MEMWAIT_MAX != 0) && (32'(wait_cnt_nxt) >= MEMWAIT_MAX))
        memwait_timeout <= 1'b1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: live cycles, PC-stalled cycles and redirects.
  // All wrap naturally at their width and freeze while halted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cyc_cnt   <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else if (state != ST_HALTED) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (!pc_en)
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_redirect)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Two instances share the stimulus:
// one with the default MEMWAIT_MAX and one with MEMWAIT_MAX=3 for the timeout.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, ex_dren, mem_dren, mem_dwen, mem_redirect, wb_halt;
  logic [4:0] id_rs, id_rt, ex_rt;

  logic pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, imemREN, dmem_req, halt, memwait_timeout;
  logic t3_pc_en, t3_pc_redirect, t3_ifid_en, t3_idex_en, t3_exmem_en, t3_memwb_en;
  logic t3_ifid_flush, t3_idex_flush, t3_exmem_flush, t3_imemREN, t3_dmem_req, t3_halt;
  logic t3_memwait_timeout;

  int errors = 0;
  int checks = 0;

  // Control bundle order:
  // pc_en pc_redirect ifid_en idex_en exmem_en memwb_en
  // ifid_flush idex_flush exmem_flush imemREN dmem_req halt
  logic [11:0] ctl, t3_ctl;
  assign ctl = {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, imemREN, dmem_req, halt};
  assign t3_ctl = {t3_pc_en, t3_pc_redirect, t3_ifid_en, t3_idex_en, t3_exmem_en, t3_memwb_en,
                   t3_ifid_flush, t3_idex_flush, t3_exmem_flush, t3_imemREN, t3_dmem_req, t3_halt};

  localparam logic [11:0] P_NORM    = 12'b1011_1100_0100;
  localparam logic [11:0] P_NORM_DR = 12'b1011_1100_0110;
  localparam logic [11:0] P_IDLE    = 12'b0000_0000_0100;
  localparam logic [11:0] P_WAIT    = 12'b0000_0000_0110;
  localparam logic [11:0] P_LU      = 12'b0001_1101_0100;
  localparam logic [11:0] P_RDIR    = 12'b1111_1111_1100;
  localparam logic [11:0] P_HALT    = 12'b0000_0000_0001;

  // Input flag order: ihit dhit ex_dren mem_dren mem_dwen mem_redirect wb_halt
  localparam logic [6:0] F_IHIT = 7'b1000000;
  localparam logic [6:0] F_DHIT = 7'b0100000;
  localparam logic [6:0] F_EXLD = 7'b0010000;
  localparam logic [6:0] F_MRD  = 7'b0001000;
  localparam logic [6:0] F_MWR  = 7'b0000100;
  localparam logic [6:0] F_RDIR = 7'b0000010;
  localparam logic [6:0] F_HALT = 7'b0000001;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_dren(ex_dren), .ex_rt(ex_rt),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .imemREN(imemREN),
    .dmem_req(dmem_req), .halt(halt), .memwait_timeout(memwait_timeout)
  );

  pipeline_hazard_ctrl #(.MEMWAIT_MAX(3)) dut_t3 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_dren(ex_dren), .ex_rt(ex_rt),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_redirect(mem_redirect), .wb_halt(wb_halt),
    .pc_en(t3_pc_en), .pc_redirect(t3_pc_redirect), .ifid_en(t3_ifid_en), .idex_en(t3_idex_en),
    .exmem_en(t3_exmem_en), .memwb_en(t3_memwb_en), .ifid_flush(t3_ifid_flush),
    .idex_flush(t3_idex_flush), .exmem_flush(t3_exmem_flush), .imemREN(t3_imemREN),
    .dmem_req(t3_dmem_req), .halt(t3_halt), .memwait_timeout(t3_memwait_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, check both instances mid-cycle, then advance.
  task automatic step(input string tag, input logic [6:0] f,
                      input logic [4:0] ert, input logic [4:0] irs, input logic [4:0] irt,
                      input logic [11:0] exp_ctl, input logic [1:0] exp_to);
    {ihit, dhit, ex_dren, mem_dren, mem_dwen, mem_redirect, wb_halt} = f;
    ex_rt = ert;
    id_rs = irs;
    id_rt = irt;
    #1;
    check({tag, ".ctl"}, {8'd0, ctl, t3_ctl}, {8'd0, exp_ctl, exp_ctl});
    check({tag, ".tmo"}, {30'd0, memwait_timeout, t3_memwait_timeout}, {30'd0, exp_to});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    {ihit, dhit, ex_dren, mem_dren, mem_dwen, mem_redirect, wb_halt} = '0;
    ex_rt = '0; id_rs = '0; id_rt = '0;
    @(posedge CLK);
    #1;

    // Reset state
    step("rst0", F_IHIT, 0, 0, 0, P_IDLE, 2'b00);
    step("rst1", 7'd0,   0, 0, 0, P_IDLE, 2'b00);
    nRST = 1'b1;

    // Normal flow, non-matching load, serviced store
    step("norm0",   F_IHIT,                 0, 0, 0, P_NORM,    2'b00);
    step("norm1",   F_IHIT | F_EXLD,        7, 5, 6, P_NORM,    2'b00);
    step("store",   F_IHIT | F_MWR | F_DHIT, 5, 5, 0, P_NORM_DR, 2'b00);

    // Load-use on rs, release, on rt, and $0 immunity
    step("lu_rs",   F_IHIT | F_EXLD,        5, 5, 3, P_LU,      2'b00);
    step("lu_rel",  F_IHIT,                 5, 5, 3, P_NORM,    2'b00);
    step("lu_rt",   F_IHIT | F_EXLD,        9, 1, 9, P_LU,      2'b00);
    step("lu_r0",   F_IHIT | F_EXLD,        0, 0, 0, P_NORM,    2'b00);

    // Icache miss stalls without entering the dcache wait
    step("imiss",   7'd0,                   0, 0, 0, P_IDLE,    2'b00);
    step("ilate",   F_IHIT,                 0, 0, 0, P_NORM,    2'b00);

    // Dcache wait: dhit four cycles after ihit; timeout at 3 on dut_t3
    step("mw_a",    F_IHIT | F_MRD,         0, 0, 0, P_WAIT,    2'b00);
    step("mw_b",    F_MRD,                  0, 0, 0, P_WAIT,    2'b00);
    step("mw_c",    F_MRD,                  0, 0, 0, P_WAIT,    2'b00);
    step("mw_d",    F_MRD,                  0, 0, 0, P_WAIT,    2'b00);
    step("mw_hit",  F_MRD | F_DHIT,         0, 0, 0, P_NORM_DR, 2'b01);
    step("mw_aft",  F_IHIT,                 0, 0, 0, P_NORM,    2'b01);

    // Ihit arriving during the wait is latched
    step("mw2_a",   F_MRD,                  0, 0, 0, P_WAIT,    2'b01);
    step("mw2_ih",  F_MRD | F_IHIT,         0, 0, 0, P_WAIT,    2'b01);
    step("mw2_hit", F_MRD | F_DHIT,         0, 0, 0, P_NORM_DR, 2'b01);

    // Dhit before ihit is latched and the request drops
    step("dfirst",  F_MRD | F_DHIT,         0, 0, 0, P_WAIT,    2'b01);
    step("dseen",   F_MRD | F_IHIT,         0, 0, 0, P_NORM,    2'b01);

    // Redirect beats load-use; redirect without advance is a plain stall
    step("rdir_lu", F_IHIT | F_RDIR | F_EXLD, 5, 5, 0, P_RDIR,  2'b01);
    step("rdir_st", F_RDIR,                 0, 0, 0, P_IDLE,    2'b01);
    step("rdir_af", F_IHIT,                 0, 0, 0, P_NORM,    2'b01);

    // Halt during a dcache wait; hits and redirects ignored afterwards
    step("h_a",     F_IHIT | F_MRD,         0, 0, 0, P_WAIT,    2'b01);
    step("h_b",     F_MRD | F_HALT,         0, 0, 0, P_WAIT,    2'b01);
    step("h_c",     F_IHIT | F_DHIT | F_MRD, 0, 0, 0, P_HALT,   2'b01);
    step("h_d",     F_IHIT | F_RDIR,        0, 0, 0, P_HALT,    2'b01);

    // One-edge reset out of HALTED clears everything, including the timeout
    nRST = 1'b0;
    step("h_rst",   F_IHIT,                 0, 0, 0, P_IDLE,    2'b01);
    nRST = 1'b1;
    step("post0",   7'd0,                   0, 0, 0, P_IDLE,    2'b00);
    step("post1",   F_IHIT,                 0, 0, 0, P_NORM,    2'b00);

    // Halt seen in RUN on an otherwise advancing cycle
    step("hr_a",    F_IHIT | F_HALT,        0, 0, 0, P_IDLE,    2'b00);
    step("hr_b",    F_IHIT,                 0, 0, 0, P_HALT,    2'b00);

    // Reset while halted, then reset mid-wait
    nRST = 1'b0;
    step("rh_rst",  F_MRD,                  0, 0, 0, P_IDLE,    2'b00);
    nRST = 1'b1;
    step("rw_a",    F_MRD,                  0, 0, 0, P_WAIT,    2'b00);
    step("rw_b",    F_MRD,                  0, 0, 0, P_WAIT,    2'b00);
    nRST = 1'b0;
    step("rw_rst",  F_MRD,                  0, 0, 0, P_IDLE,    2'b00);
    nRST = 1'b1;
    step("rw_c",    7'd0,                   0, 0, 0, P_IDLE,    2'b00);
    step("rw_d",    F_IHIT,                 0, 0, 0, P_NORM,    2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
